tm_qm0_sch: RTL and testbench

First-level queue scheduler that sits directly downstream of the first-level queue-depth tracker (`tm_qm0_depth`). It keeps a round-robin active list of non-empty first-level queues and issues dequeue requests to the depth tracker. It consumes the tracker's enqueue/dequeue acknowledges and their empty/non-empty indications to add queues to the list, rotate them, or retire them. It also snoops the egress-processor enqueue request stream so every acknowledge can be paired with its queue id.

---
 rtl/tm_qm0_sch_pkg.sv | 16 +
 rtl/sfifo2f_fo.sv | 51 +++++
 rtl/tm_qm0_sch.sv | 138 +++++++++++++
 tb/tb_tm_qm0_sch.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm_qm0_sch_pkg.sv
// Shared widths and error-cause encoding for the first-level queue scheduler.
package tm_qm0_sch_pkg;

    localparam int FIRST_LVL_QUEUE_ID_NBITS = 4;

    // Bit positions in the per-cycle error cause vector.
    typedef enum logic [1:0] {
        ERR_LIST_OVF = 2'd0,
        ERR_PEND_OVF = 2'd1,
        ERR_ENQ_UNF  = 2'd2,
        ERR_DEQ_UNF  = 2'd3
    } sch_err_cause_e;

    localparam int SCH_ERR_NCAUSE = 4;

endpackage

// File: rtl/sfifo2f_fo.sv
// Small synchronous FIFO with first-word fall-through read data.
// Pushes while full and pops while empty are ignored; the owner flags them.
module sfifo2f_fo #(
    parameter int DW = 4,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          wr_en;
    logic          rd_en;

    assign full_o  = (cnt_q == {1'b1, {AW{1'b0}}});
    assign empty_o = (cnt_q == '0);
    assign wr_en   = push_i & ~full_o;
    assign rd_en   = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

endmodule

// File: rtl/tm_qm0_sch.sv
// First-level round-robin scheduler: keeps the active list of non-empty queues
// and issues spaced dequeue requests to the depth tracker.
module tm_qm0_sch
    import tm_qm0_sch_pkg::*;
#(
    parameter int QW              = FIRST_LVL_QUEUE_ID_NBITS,
    parameter int PEND_DEPTH_LOG2 = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enq_req,
    input  logic [QW-1:0] enq_qid,
    input  logic          enq_ack,
    input  logic          enq_to_empty,
    input  logic          deq_ack,
    input  logic          deq_from_emptyp2,
    input  logic          sch_en,
    output logic          deq_req,
    output logic [QW-1:0] deq_qid,
    output logic [QW:0]   active_count,
    output logic          sch_err
);
    localparam int          LIST_N   = 1 << QW;
    localparam logic [QW:0] LIST_CAP = {1'b1, {QW{1'b0}}};

    logic [QW-1:0] list_q [LIST_N];
    logic [QW-1:0] head_q;
    logic [QW-1:0] tail_q;
    logic [QW:0]   count_q;
    logic [QW:0]   count_d;
    logic [QW:0]   count_pushed;
    logic          deq_req_q;
    logic          deq_req_d;
    logic [QW-1:0] deq_qid_q;
    logic [QW-1:0] deq_qid_d;
    logic          sch_err_q;

    logic          enq_pend_full;
    logic          enq_pend_empty;
    logic          deq_pend_full;
    logic          deq_pend_empty;
    logic [QW-1:0] enq_pend_qid;
    logic [QW-1:0] deq_pend_qid;

    logic          deq_push_req;
    logic          enq_push_req;
    logic          deq_push_ok;
    logic          enq_push_ok;
    logic          issue;
    logic [QW-1:0] enq_wr_idx;
    logic [QW-1:0] head_qid;
    logic [SCH_ERR_NCAUSE-1:0] err_vec;

    sfifo2f_fo #(.DW(QW), .AW(PEND_DEPTH_LOG2)) u_enq_pend (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (enq_req),
        .din_i   (enq_qid),
        .pop_i   (enq_ack),
        .dout_o  (enq_pend_qid),
        .full_o  (enq_pend_full),
        .empty_o (enq_pend_empty)
    );

    sfifo2f_fo #(.DW(QW), .AW(PEND_DEPTH_LOG2)) u_deq_pend (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (deq_req_q),
        .din_i   (deq_qid_q),
        .pop_i   (deq_ack),
        .dout_o  (deq_pend_qid),
        .full_o  (deq_pend_full),
        .empty_o (deq_pend_empty)
    );

    always_comb begin
        deq_push_req = deq_ack & ~deq_pend_empty & deq_from_emptyp2;
        enq_push_req = enq_ack & ~enq_pend_empty & enq_to_empty;
        deq_push_ok  = deq_push_req & (count_q != LIST_CAP);
        enq_push_ok  = enq_push_req & ((count_q + (QW+1)'(deq_push_ok)) != LIST_CAP);
        count_pushed = count_q + (QW+1)'(deq_push_ok) + (QW+1)'(enq_push_ok);
        // The rotated queue takes the tail slot ahead of a newly active one.
        enq_wr_idx   = tail_q + QW'(deq_push_ok);

        // Bypass: an empty list can issue straight from this cycle's push.
        if (count_q != '0) begin
            head_qid = list_q[head_q];
        end else if (deq_push_ok) begin
            head_qid = deq_pend_qid;
        end else begin
            head_qid = enq_pend_qid;
        end

        issue     = (count_pushed != '0) & sch_en & ~deq_req_q;
        count_d   = count_pushed - (QW+1)'(issue);
        deq_req_d = issue;
        deq_qid_d = issue ? head_qid : deq_qid_q;

        err_vec               = '0;
        err_vec[ERR_LIST_OVF] = (deq_push_req & ~deq_push_ok) | (enq_push_req & ~enq_push_ok);
        err_vec[ERR_PEND_OVF] = (enq_req & enq_pend_full) | (deq_req_q & deq_pend_full);
        err_vec[ERR_ENQ_UNF]  = enq_ack & enq_pend_empty;
        err_vec[ERR_DEQ_UNF]  = deq_ack & deq_pend_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LIST_N; i++) begin
                list_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            deq_req_q <= 1'b0;
            deq_qid_q <= '0;
            sch_err_q <= 1'b0;
        end else begin
            if (deq_push_ok) begin
                list_q[tail_q] <= deq_pend_qid;
            end
            if (enq_push_ok) begin
                list_q[enq_wr_idx] <= enq_pend_qid;
            end
            tail_q    <= tail_q + QW'(deq_push_ok) + QW'(enq_push_ok);
            head_q    <= head_q + QW'(issue);
            count_q   <= count_d;
            deq_req_q <= deq_req_d;
            deq_qid_q <= deq_qid_d;
            sch_err_q <= sch_err_q | (|err_vec);
        end
    end

    assign deq_req      = deq_req_q;
    assign deq_qid      = deq_qid_q;
    assign active_count = count_q;
    assign sch_err      = sch_err_q;

endmodule

// File: tb/tb_tm_qm0_sch.sv
// Bench for tm_qm0_sch: a behavioural depth tracker answers the scheduler,
// expected issue order is queued per scenario and popped on every deq_req.
module tb_tm_qm0_sch;
    import tm_qm0_sch_pkg::*;

    localparam int QW = FIRST_LVL_QUEUE_ID_NBITS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enq_req;
    logic [QW-1:0] enq_qid;
    logic          enq_ack;
    logic          enq_to_empty;
    logic          deq_ack;
    logic          deq_from_emptyp2;
    logic          sch_en;
    logic          deq_req;
    logic [QW-1:0] deq_qid;
    logic [QW:0]   active_count;
    logic          sch_err;

    always #5 clk = ~clk;

    tm_qm0_sch #(.QW(QW), .PEND_DEPTH_LOG2(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enq_req          (enq_req),
        .enq_qid          (enq_qid),
        .enq_ack          (enq_ack),
        .enq_to_empty     (enq_to_empty),
        .deq_ack          (deq_ack),
        .deq_from_emptyp2 (deq_from_emptyp2),
        .sch_en           (sch_en),
        .deq_req          (deq_req),
        .deq_qid          (deq_qid),
        .active_count     (active_count),
        .sch_err          (sch_err)
    );

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            n_issue = 0;
    int            last_deq_cyc = -1;
    int            depth [16];
    logic          dp_v [3];
    logic [QW-1:0] dp_q [3];
    logic          prev_enq;
    logic [QW-1:0] prev_qid;
    logic          nxt_enq;
    logic [QW-1:0] nxt_qid;
    logic          spur_deq;
    logic [QW-1:0] exp_q [$];

    typedef struct {
        logic [QW-1:0] qa;
        logic [QW-1:0] qb;
        logic [QW-1:0] qc;
        int            dpth;
        int            exp_issues;
    } rr_vec_t;

    rr_vec_t tbl [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) depth[i] = 0;
        for (int i = 0; i < 3; i++) begin
            dp_v[i] = 1'b0;
            dp_q[i] = '0;
        end
        prev_enq = 1'b0;
        prev_qid = '0;
        nxt_enq  = 1'b0;
        nxt_qid  = '0;
        spur_deq = 1'b0;
        exp_q.delete();
        last_deq_cyc     = -1;
        enq_req          = 1'b0;
        enq_qid          = '0;
        enq_ack          = 1'b0;
        enq_to_empty     = 1'b0;
        deq_ack          = 1'b0;
        deq_from_emptyp2 = 1'b0;
    endtask

    // One clock: score this cycle's deq_req, then drive tracker acks and stimulus.
    task automatic tick();
        logic          a_deq;
        logic          a_enq;
        logic [QW-1:0] dq;
        logic [QW-1:0] eq;
        logic          fe2;
        logic          te;
        @(posedge clk);
        #1;
        cyc++;
        a_deq   = dp_v[0];
        dq      = dp_q[0];
        dp_v[0] = dp_v[1];
        dp_q[0] = dp_q[1];
        dp_v[1] = dp_v[2];
        dp_q[1] = dp_q[2];
        dp_v[2] = 1'b0;
        dp_q[2] = '0;
        if (deq_req === 1'b1) begin
            n_issue++;
            if (last_deq_cyc >= 0) chk("issue_spacing_ge2", 32'(cyc - last_deq_cyc >= 2), 1);
            last_deq_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_deq_req: got qid %0d, expected no request (cycle %0d)", deq_qid, cyc);
            end else begin
                chk("deq_qid", 32'(deq_qid), 32'(exp_q.pop_front()));
            end
            dp_v[2] = 1'b1;
            dp_q[2] = deq_qid;
        end
        a_enq = prev_enq;
        eq    = prev_qid;
        fe2   = 1'b1;
        te    = 1'b0;
        if (a_deq) begin
            fe2 = depth[dq] > 1;
            depth[dq]--;
        end
        if (a_enq) begin
            te = depth[eq] == 0;
            depth[eq]++;
        end
        deq_ack          = a_deq | spur_deq;
        deq_from_emptyp2 = fe2;
        enq_ack          = a_enq;
        enq_to_empty     = te;
        spur_deq         = 1'b0;
        enq_req          = nxt_enq;
        enq_qid          = nxt_qid;
        prev_enq         = nxt_enq;
        prev_qid         = nxt_qid;
        nxt_enq          = 1'b0;
    endtask

    task automatic enq(input logic [QW-1:0] q);
        nxt_enq = 1'b1;
        nxt_qid = q;
        tick();
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || dp_v[0] || dp_v[1] || dp_v[2] || prev_enq ||
                active_count != 0) && k < 300) begin
            tick();
            k++;
        end
        if (k >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_drain: got %0d issues still pending, expected 0 (timeout)", name, exp_q.size());
        end
        tick();
        tick();
        tick();
        chk({name, "_active_count_end"}, 32'(active_count), 0);
        chk({name, "_pending_expected"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        int k;
        int n0;
        int t_ack;
        #400000;
        $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int n0;
        int t_ack;
        tbl[0] = '{qa: 4'd3,  qb: 4'd7, qc: 4'd9,  dpth: 2, exp_issues: 6};
        tbl[1] = '{qa: 4'd1,  qb: 4'd0, qc: 4'd15, dpth: 1, exp_issues: 3};
        tbl[2] = '{qa: 4'd12, qb: 4'd4, qc: 4'd6,  dpth: 3, exp_issues: 9};

        rst_n  = 1'b0;
        sch_en = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_deq_req", 32'(deq_req), 0);
        chk("reset_deq_qid", 32'(deq_qid), 0);
        chk("reset_active_count", 32'(active_count), 0);
        chk("reset_sch_err", 32'(sch_err), 0);
        rst_n = 1'b1;
        tick();

        // Single queue, bypass issue one cycle after the enqueue ack.
        sch_en = 1'b1;
        exp_q.push_back(4'd5);
        enq(4'd5);
        t_ack = cyc + 1;
        tick();
        tick();
        chk("t1_deq_req_after_ack", 32'(deq_req), 1);
        chk("t1_issue_latency", 32'(last_deq_cyc - t_ack), 1);
        chk("t1_active_count_bypass", 32'(active_count), 0);
        drain("t1");

        // Same queue with scheduling held off: count visibly goes to 1.
        sch_en = 1'b0;
        enq(4'd5);
        tick();
        tick();
        chk("t1b_active_count_one", 32'(active_count), 1);
        exp_q.push_back(4'd5);
        sch_en = 1'b1;
        drain("t1b");

        // Round-robin table: interleaved enqueues, issue order repeats qa,qb,qc.
        for (int v = 0; v < 3; v++) begin
            sch_en = 1'b1;
            n0     = n_issue;
            for (int r = 0; r < tbl[v].dpth; r++) begin
                exp_q.push_back(tbl[v].qa);
                exp_q.push_back(tbl[v].qb);
                exp_q.push_back(tbl[v].qc);
            end
            for (int r = 0; r < tbl[v].dpth; r++) begin
                enq(tbl[v].qa);
                enq(tbl[v].qb);
                enq(tbl[v].qc);
            end
            drain("rr");
            chk("rr_issue_count", 32'(n_issue - n0), 32'(tbl[v].exp_issues));
            chk("rr_sch_err", 32'(sch_err), 0);
        end

        // Rotation of qid 2 and new activation of qid 4 in the same cycle.
        sch_en = 1'b1;
        exp_q.push_back(4'd2);
        enq(4'd2);
        enq(4'd2);
        k = 0;
        while (deq_req !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("dual_first_issue_seen", 32'(deq_req), 1);
        sch_en = 1'b0;
        tick();
        nxt_enq = 1'b1;
        nxt_qid = 4'd4;
        tick();
        tick();
        chk("dual_count_before", 32'(active_count), 0);
        tick();
        chk("dual_count_after", 32'(active_count), 2);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd4);
        sch_en = 1'b1;
        drain("dual");
        chk("dual_sch_err", 32'(sch_err), 0);

        // Held scheduling, spurious deq_ack, then resume from the oldest head.
        sch_en = 1'b0;
        n0     = n_issue;
        enq(4'd11);
        enq(4'd12);
        enq(4'd13);
        repeat (4) tick();
        chk("hold_no_issue", 32'(n_issue - n0), 0);
        chk("hold_active_count", 32'(active_count), 3);
        spur_deq = 1'b1;
        tick();
        tick();
        chk("spur_sch_err_set", 32'(sch_err), 1);
        chk("spur_list_unchanged", 32'(active_count), 3);
        repeat (3) tick();
        chk("spur_sch_err_sticky", 32'(sch_err), 1);
        exp_q.push_back(4'd11);
        exp_q.push_back(4'd12);
        exp_q.push_back(4'd13);
        sch_en = 1'b1;
        tick();
        chk("resume_latency", 32'(deq_req), 1);
        drain("resume");
        chk("resume_sch_err_still", 32'(sch_err), 1);

        // Asynchronous reset while dequeues are outstanding.
        n0 = n_issue;
        for (int q = 1; q <= 4; q++) exp_q.push_back(4'(q));
        for (int r = 0; r < 2; r++) begin
            for (int q = 1; q <= 4; q++) enq(4'(q));
        end
        k = 0;
        while ((n_issue - n0) < 4 && k < 40) begin
            tick();
            k++;
        end
        chk("rst_issues_before", 32'(n_issue - n0), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_deq_req", 32'(deq_req), 0);
        chk("async_rst_deq_qid", 32'(deq_qid), 0);
        chk("async_rst_active_count", 32'(active_count), 0);
        chk("async_rst_sch_err", 32'(sch_err), 0);
        clear_model();
        tick();
        tick();
        rst_n  = 1'b1;
        sch_en = 1'b1;
        tick();
        exp_q.push_back(4'd6);
        exp_q.push_back(4'd8);
        enq(4'd6);
        enq(4'd8);
        drain("post_rst");
        chk("post_rst_sch_err", 32'(sch_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
